// File: rtl/l2_mem_arbiter.sv
// Round-robin sharing of the single L2-to-AXI bridge request port between NREQ requesters.
// One outstanding transaction; responses go only to the granted requester.
//  state | meaning
//  IDLE  | no owner; pick the first valid requester searching up from rr_ptr_q
//  REQ   | request presented to the bridge on behalf of grant_q
//  RESP  | request accepted; bridge responses routed to grant_q until ack
module l2_mem_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDR_BITS = 48,
    parameter int LINE_BITS = 256,
    parameter int TYPE_BITS = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NREQ-1:0]               i_s_req_valid,
    input  logic [NREQ*TYPE_BITS-1:0]     i_s_req_type,
    input  logic [NREQ*3-1:0]             i_s_req_size,
    input  logic [NREQ*3-1:0]             i_s_req_prot,
    input  logic [NREQ*ADDR_BITS-1:0]     i_s_req_addr,
    input  logic [NREQ*LINE_BITS/8-1:0]   i_s_req_strob,
    input  logic [NREQ*LINE_BITS-1:0]     i_s_req_data,
    output logic [NREQ-1:0]               o_s_req_ready,
    output logic [NREQ-1:0]               o_s_resp_valid,
    output logic [NREQ-1:0]               o_s_resp_ack,
    output logic [NREQ-1:0]               o_s_resp_load_fault,
    output logic [NREQ-1:0]               o_s_resp_store_fault,
    output logic [LINE_BITS-1:0]          o_s_resp_data,
    output logic                          o_m_req_valid,
    output logic [TYPE_BITS-1:0]          o_m_req_type,
    output logic [2:0]                    o_m_req_size,
    output logic [2:0]                    o_m_req_prot,
    output logic [ADDR_BITS-1:0]          o_m_req_addr,
    output logic [LINE_BITS/8-1:0]        o_m_req_strob,
    output logic [LINE_BITS-1:0]          o_m_req_data,
    input  logic                          i_m_req_ready,
    input  logic                          i_m_resp_valid,
    input  logic                          i_m_resp_ack,
    input  logic                          i_m_resp_load_fault,
    input  logic                          i_m_resp_store_fault,
    input  logic [LINE_BITS-1:0]          i_m_resp_data
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int STRB_BITS = LINE_BITS / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           state_q;
    logic [PTR_W-1:0] grant_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic             m_req_valid_q;
    logic [PTR_W-1:0] grant_d;
    logic             found_d;
    int               idx_c;
    logic [PTR_W-1:0] idx_p;
    logic             resp_en;

    // Round-robin search, wrapping at NREQ so non-power-of-2 counts stay in range.
    always_comb begin
        grant_d = rr_ptr_q;
        found_d = 1'b0;
        idx_c   = 0;
        idx_p   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_c = int'(rr_ptr_q) + k;
            if (idx_c >= NREQ) idx_c = idx_c - NREQ;
            idx_p = PTR_W'(idx_c);
            if (!found_d && i_s_req_valid[idx_p]) begin
                found_d = 1'b1;
                grant_d = idx_p;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            m_req_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q       <= grant_d;
                        m_req_valid_q <= 1'b1;
                        state_q       <= REQ;
                    end
                end
                REQ: begin
                    if (i_m_req_ready) begin
                        m_req_valid_q <= 1'b0;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (i_m_resp_ack) begin
                        rr_ptr_q <= (grant_q == PTR_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    m_req_valid_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign resp_en       = (state_q == RESP);
    assign o_m_req_valid = m_req_valid_q;
    assign o_s_resp_data = i_m_resp_data;

    // Request fields follow grant_q; ready and responses only reach the owner.
    always_comb begin
        o_m_req_type         = '0;
        o_m_req_size         = '0;
        o_m_req_prot         = '0;
        o_m_req_addr         = '0;
        o_m_req_strob        = '0;
        o_m_req_data         = '0;
        o_s_req_ready        = '0;
        o_s_resp_valid       = '0;
        o_s_resp_ack         = '0;
        o_s_resp_load_fault  = '0;
        o_s_resp_store_fault = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == PTR_W'(i)) begin
                o_m_req_type            = i_s_req_type[i*TYPE_BITS +: TYPE_BITS];
                o_m_req_size            = i_s_req_size[i*3 +: 3];
                o_m_req_prot            = i_s_req_prot[i*3 +: 3];
                o_m_req_addr            = i_s_req_addr[i*ADDR_BITS +: ADDR_BITS];
                o_m_req_strob           = i_s_req_strob[i*STRB_BITS +: STRB_BITS];
                o_m_req_data            = i_s_req_data[i*LINE_BITS +: LINE_BITS];
                o_s_req_ready[i]        = m_req_valid_q & i_m_req_ready;
                o_s_resp_valid[i]       = resp_en & i_m_resp_valid;
                o_s_resp_ack[i]         = resp_en & i_m_resp_ack;
                o_s_resp_load_fault[i]  = resp_en & i_m_resp_load_fault;
                o_s_resp_store_fault[i] = resp_en & i_m_resp_store_fault;
            end
        end
    end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level ownership model.
module tb_l2_mem_arbiter;
    localparam int NREQ = 2;
    localparam int AB   = 48;
    localparam int LB   = 256;
    localparam int TB   = 3;
    localparam int SB   = LB / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0] r_valid = '0;
    logic [TB-1:0]   r_type [NREQ];
    logic [2:0]      r_size [NREQ];
    logic [2:0]      r_prot [NREQ];
    logic [AB-1:0]   r_addr [NREQ];
    logic [SB-1:0]   r_strob[NREQ];
    logic [LB-1:0]   r_data [NREQ];

    logic [NREQ*TB-1:0] s_type;
    logic [NREQ*3-1:0]  s_size, s_prot;
    logic [NREQ*AB-1:0] s_addr;
    logic [NREQ*SB-1:0] s_strob;
    logic [NREQ*LB-1:0] s_data;

    always_comb begin
        s_type = '0; s_size = '0; s_prot = '0; s_addr = '0; s_strob = '0; s_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            s_type[i*TB +: TB]  = r_type[i];
            s_size[i*3 +: 3]    = r_size[i];
            s_prot[i*3 +: 3]    = r_prot[i];
            s_addr[i*AB +: AB]  = r_addr[i];
            s_strob[i*SB +: SB] = r_strob[i];
            s_data[i*LB +: LB]  = r_data[i];
        end
    end

    logic m_ready = 1'b0, m_rv = 1'b0, m_ack = 1'b0, m_lf = 1'b0, m_sf = 1'b0;
    logic [LB-1:0] m_rdata = '0;

    logic [NREQ-1:0] o_s_req_ready, o_s_resp_valid, o_s_resp_ack, o_s_resp_load_fault, o_s_resp_store_fault;
    logic [LB-1:0]   o_s_resp_data;
    logic            o_m_req_valid;
    logic [TB-1:0]   o_m_req_type;
    logic [2:0]      o_m_req_size, o_m_req_prot;
    logic [AB-1:0]   o_m_req_addr;
    logic [SB-1:0]   o_m_req_strob;
    logic [LB-1:0]   o_m_req_data;

    l2_mem_arbiter #(.NREQ(NREQ), .ADDR_BITS(AB), .LINE_BITS(LB), .TYPE_BITS(TB)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_s_req_valid(r_valid), .i_s_req_type(s_type), .i_s_req_size(s_size),
        .i_s_req_prot(s_prot), .i_s_req_addr(s_addr), .i_s_req_strob(s_strob),
        .i_s_req_data(s_data),
        .o_s_req_ready(o_s_req_ready), .o_s_resp_valid(o_s_resp_valid),
        .o_s_resp_ack(o_s_resp_ack), .o_s_resp_load_fault(o_s_resp_load_fault),
        .o_s_resp_store_fault(o_s_resp_store_fault), .o_s_resp_data(o_s_resp_data),
        .o_m_req_valid(o_m_req_valid), .o_m_req_type(o_m_req_type),
        .o_m_req_size(o_m_req_size), .o_m_req_prot(o_m_req_prot),
        .o_m_req_addr(o_m_req_addr), .o_m_req_strob(o_m_req_strob),
        .o_m_req_data(o_m_req_data),
        .i_m_req_ready(m_ready), .i_m_resp_valid(m_rv), .i_m_resp_ack(m_ack),
        .i_m_resp_load_fault(m_lf), .i_m_resp_store_fault(m_sf), .i_m_resp_data(m_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: who owns the bridge, whether the bridge took the request,
    // and where the next round-robin search begins.
    int              owner    = -1;
    bit              accepted = 1'b0;
    int              nxt      = 0;
    logic [NREQ-1:0] r_done   = '0;

    task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        v = '0;
        for (int k = 0; k < LB / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_model();
        logic [NREQ-1:0] oh;
        bit pend;
        bit live;
        #1;
        oh   = (owner >= 0) ? (NREQ'(1) << owner) : '0;
        pend = (owner >= 0) && !accepted;
        live = (owner >= 0) && accepted;
        chk("m_req_valid", o_m_req_valid, pend);
        if (pend) begin
            chk("m_req_addr", o_m_req_addr, r_addr[owner]);
            chk("m_req_type", o_m_req_type, r_type[owner]);
            chk("m_req_size", o_m_req_size, r_size[owner]);
            chk("m_req_prot", o_m_req_prot, r_prot[owner]);
            chk("m_req_strob", o_m_req_strob, r_strob[owner]);
            chk("m_req_data", o_m_req_data, r_data[owner]);
        end
        chk("s_req_ready", o_s_req_ready, (pend && m_ready) ? oh : '0);
        chk("s_resp_valid", o_s_resp_valid, (live && m_rv) ? oh : '0);
        chk("s_resp_ack", o_s_resp_ack, (live && m_ack) ? oh : '0);
        chk("s_resp_load_fault", o_s_resp_load_fault, (live && m_lf) ? oh : '0);
        chk("s_resp_store_fault", o_s_resp_store_fault, (live && m_sf) ? oh : '0);
        if (live && m_rv) chk("s_resp_data", o_s_resp_data, m_rdata);
    endtask

    task automatic update_model();
        if (rst) begin
            owner = -1; accepted = 1'b0; nxt = 0;
        end else if (owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (nxt + k) % NREQ;
                if (owner < 0 && r_valid[idx]) owner = idx;
            end
        end else if (!accepted) begin
            if (m_ready) begin accepted = 1'b1; r_done[owner] = 1'b1; end
        end else if (m_ack) begin
            nxt = (owner + 1) % NREQ; owner = -1; accepted = 1'b0;
        end
    endtask

    task automatic step();
        check_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic wait_mvalid(input string nm, output int n);
        n = 0;
        #1;
        while (!o_m_req_valid && n < 8) begin step(); #1; n++; end
        if (!o_m_req_valid) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: o_m_req_valid still 0 after %0d cycles, required 1", nm, n);
        end
    endtask

    task automatic grant_txn(input logic [NREQ-1:0] vm, input logic [NREQ-1:0] exp,
                             input string nm, input bit do_ack);
        int n;
        r_valid = vm;
        wait_mvalid(nm, n);
        m_ready = 1'b1; #1;
        chk(nm, o_s_req_ready, exp);
        step();
        m_ready = 1'b0; r_valid = '0;
        if (do_ack) begin m_rv = 1'b1; m_ack = 1'b1; step(); m_rv = 1'b0; m_ack = 1'b0; end
    endtask

    initial begin
        int n, c0, c1, ca;
        for (int i = 0; i < NREQ; i++) begin
            r_type[i] = '0; r_size[i] = '0; r_prot[i] = '0;
            r_addr[i] = '0; r_strob[i] = '0; r_data[i] = '0;
        end
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_m_req_valid", o_m_req_valid, 0);
        chk("rst_s_req_ready", o_s_req_ready, 0);

        // Single read from requester 0, then its response with ack.
        r_addr[0] = 48'h0000_8000_1000; r_type[0] = 3'b000; r_valid = 2'b01;
        #1; chk("t1_no_comb_path", o_m_req_valid, 0);
        step();
        m_ready = 1'b1; #1;
        chk("t1_m_req_valid", o_m_req_valid, 1);
        chk("t1_m_req_addr", o_m_req_addr, 48'h8000_1000);
        chk("t1_s_req_ready", o_s_req_ready, 2'b01);
        step();
        m_ready = 1'b0; r_valid = '0;
        m_rv = 1'b1; m_ack = 1'b1; m_rdata = {32{8'hA5}}; #1;
        chk("t1_ready_once", o_s_req_ready, 0);
        chk("t2_resp_valid", o_s_resp_valid, 2'b01);
        chk("t2_resp_ack", o_s_resp_ack, 2'b01);
        chk("t2_resp_data", o_s_resp_data, {32{8'hA5}});
        step();
        m_ack = 1'b0; #1;
        chk("t2_idle_resp_ignored", o_s_resp_valid, 0);
        step();
        m_rv = 1'b0;

        // Both requesters always valid: alternating grant, two-cycle ack-to-request gap.
        do_reset();
        r_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_mvalid("t3", n);
            if (t > 0) chk($sformatf("t3_gap%0d", t), n + 1, 2);
            m_ready = 1'b1; #1;
            chk($sformatf("t3_grant%0d", t), o_s_req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
            step();
            m_ready = 1'b0; m_rv = 1'b1; m_ack = 1'b1;
            step();
            m_rv = 1'b0; m_ack = 1'b0;
        end

        // Requester 1 write with a store fault on the ack beat.
        r_type[1] = 3'b010; r_addr[1] = 48'h0000_0000_4000;
        grant_txn(2'b10, 2'b10, "t4_grant", 1'b0);
        m_rv = 1'b1; m_ack = 1'b1; m_sf = 1'b1; #1;
        chk("t4_store_fault", o_s_resp_store_fault, 2'b10);
        chk("t4_load_fault", o_s_resp_load_fault, 0);
        step();
        m_rv = 1'b0; m_ack = 1'b0; m_sf = 1'b0;

        // Four-beat response to requester 1.
        grant_txn(2'b10, 2'b10, "t5_grant", 1'b0);
        c0 = 0; c1 = 0; ca = 0;
        for (int b = 0; b < 4; b++) begin
            m_rv = 1'b1; m_ack = (b == 3); m_rdata = rand_line(); #1;
            c0 += int'(o_s_resp_valid[0]); c1 += int'(o_s_resp_valid[1]);
            ca += int'(o_s_resp_ack[0]) + int'(o_s_resp_ack[1]);
            step();
        end
        m_rv = 1'b0; m_ack = 1'b0;
        chk("t5_beats_req1", c1, 4);
        chk("t5_beats_req0", c0, 0);
        chk("t5_acks", ca, 1);

        // Reset during a response clears everything, including the round-robin pointer.
        grant_txn(2'b01, 2'b01, "t6_grant_a", 1'b1);
        grant_txn(2'b01, 2'b01, "t6_grant_b", 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        m_ready = 1'b1; m_rv = 1'b1; #1;
        chk("t6_m_req_valid", o_m_req_valid, 0);
        chk("t6_s_req_ready", o_s_req_ready, 0);
        chk("t6_s_resp_valid", o_s_resp_valid, 0);
        step();
        m_ready = 1'b0; m_rv = 1'b0;
        grant_txn(2'b11, 2'b01, "t6_rr_ptr_zero", 1'b1);
        grant_txn(2'b10, 2'b10, "t6_req1_after_rst", 1'b1);

        // Random traffic against the model.
        do_reset();
        r_done = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_done[i]) begin r_valid[i] = 1'b0; r_done[i] = 1'b0; end
                if (!r_valid[i] && $urandom_range(0, 2) == 0) begin
                    r_valid[i] = 1'b1;
                    r_type[i]  = TB'($urandom);
                    r_size[i]  = 3'($urandom);
                    r_prot[i]  = 3'($urandom);
                    r_addr[i]  = AB'({$urandom, $urandom});
                    r_strob[i] = SB'($urandom);
                    r_data[i]  = rand_line();
                end
            end
            m_ready = ($urandom_range(0, 1) == 1);
            m_rv    = ($urandom_range(0, 1) == 1);
            m_ack   = ($urandom_range(0, 3) == 0);
            m_lf    = ($urandom_range(0, 3) == 0);
            m_sf    = ($urandom_range(0, 3) == 0);
            m_rdata = rand_line();
            rst     = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
